pipeline_ctrl: RTL and testbench

//  Central stall/flush/valid controller for the N-stage pipelined datapath.

---
 rtl/dp_types_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_types_pkg.sv
// Shared types for the pipelined datapath control slice.
// Pipe states and the canonical latch numbering.
package dp_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/valid controller for the pipelined datapath.
// Owns latch valid bits, the run/drain/halt FSM and perf counters.
module pipeline_ctrl
    import dp_types_pkg::*;
#(
    parameter int NLATCH      = 4,
    parameter int ID_EX_IDX   = ID_EX,
    parameter int MEM_IDX     = EX_MEM,
    parameter int RESOLVE_IDX = EX_MEM,
    parameter int CNT_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmem_req,
    input  logic              load_use,
    input  logic              redirect,
    input  logic              halt_dec,
    output logic [NLATCH-1:0] latch_en,
    output logic [NLATCH-1:0] latch_flush,
    output logic [NLATCH-1:0] valid,
    output logic              pc_en,
    output logic              halt,
    output pipe_state_t       state,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int PW = $clog2(NLATCH);
    localparam logic [PW-1:0] LAST = PW'(NLATCH - 1);
    localparam logic [PW-1:0] RES_POS = PW'(RESOLVE_IDX);
    localparam logic [NLATCH-1:0] SQ_MASK =
        NLATCH'((1 << RESOLVE_IDX) - 1);
    localparam logic [NLATCH-1:0] LU_EN =
        ~NLATCH'((1 << ID_EX_IDX) - 1);
    localparam logic [NLATCH-1:0] LU_FL =
        NLATCH'(1 << ID_EX_IDX);
    localparam logic [NLATCH-1:0] L0 = NLATCH'(1);

    pipe_state_t       state_q, state_d;
    logic [NLATCH-1:0] valid_q, valid_d;
    logic [PW-1:0]     pos_q, pos_d;

    logic run, drn, live;
    logic mem_freeze, older, redir_ok;
    logic sel_frz, sel_red, sel_lu, sel_drn, sel_miss, sel_go;
    logic [NLATCH-1:0] prev;

    always_comb begin
        run  = (state_q == RUN);
        drn  = (state_q == DRAIN);
        live = run | drn;

        mem_freeze = valid_q[MEM_IDX] & dmem_req & ~dhit;
        // Only a branch older than the HALT may cancel a drain.
        older    = (pos_q < RES_POS);
        redir_ok = redirect & valid_q[RESOLVE_IDX]
                 & (run | (drn & older));

        sel_frz  = live & mem_freeze;
        sel_red  = live & ~mem_freeze & redir_ok;
        sel_lu   = run & ~sel_frz & ~sel_red
                 & load_use & valid_q[ID_EX_IDX-1];
        sel_drn  = ~sel_frz & ~sel_red & ~sel_lu
                 & (drn | (run & halt_dec & valid_q[0]));
        sel_miss = run & ~sel_frz & ~sel_red & ~sel_lu
                 & ~sel_drn & ~ihit;
        sel_go   = run & ~sel_frz & ~sel_red & ~sel_lu
                 & ~sel_drn & ihit;
    end

    always_comb begin
        latch_en    = '0;
        latch_flush = '0;
        pc_en       = 1'b0;
        state_d     = state_q;
        pos_d       = pos_q;

        unique case (1'b1)
            sel_frz: begin
                latch_en = '0;
            end
            sel_red: begin
                latch_en    = '1;
                latch_flush = SQ_MASK;
                pc_en       = 1'b1;
                state_d     = RUN;
            end
            sel_lu: begin
                latch_en    = LU_EN;
                latch_flush = LU_FL;
            end
            sel_drn: begin
                latch_en    = '1;
                latch_flush = L0;
                pos_d       = run ? PW'(1) : pos_q + PW'(1);
                state_d     = (drn && pos_q == LAST) ? HALTED : DRAIN;
            end
            sel_miss: begin
                latch_en    = '1;
                latch_flush = L0;
            end
            sel_go: begin
                latch_en = '1;
                pc_en    = 1'b1;
            end
            default: begin
                latch_en = '0;
            end
        endcase
    end

    // Latch 0 always fetches a fresh instruction when enabled.
    assign prev = {valid_q[NLATCH-2:0], 1'b1};

    always_comb begin
        valid_d = (latch_en & ~latch_flush & prev)
                | (~latch_en & valid_q);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            valid_q <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
        end
    end

    assign valid = valid_q;
    assign state = state_q;
    assign halt  = (state_q == HALTED);

    sat_counter #(.W(CNT_W)) u_cyc (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (live),
        .clr  (1'b0),
        .cnt  (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (sel_frz | sel_lu),
        .clr  (1'b0),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (sel_red),
        .clr  (1'b0),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expectations are queued
// as stimulus is driven and popped when the outputs are sampled.
module tb_pipeline_ctrl;
    import dp_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, dmem_req = 1'b0;
    logic load_use = 1'b0, redirect = 1'b0, halt_dec = 1'b0;
    logic [3:0] latch_en, latch_flush, valid;
    logic pc_en, halt;
    pipe_state_t state;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmem_req    (dmem_req),
        .load_use    (load_use),
        .redirect    (redirect),
        .halt_dec    (halt_dec),
        .latch_en    (latch_en),
        .latch_flush (latch_flush),
        .valid       (valid),
        .pc_en       (pc_en),
        .halt        (halt),
        .state       (state),
        .cyc_cnt     (cyc_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // ctl = {pc_en, flush, en}; st = {halt, state, valid}
    logic [8:0] ctl;
    logic [6:0] st;
    assign ctl = {pc_en, latch_flush, latch_en};
    assign st  = {halt, state, valid};

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int exp_cyc = 0;
    bit halted = 1'b0;

    task automatic drive(input logic ih, input logic dh, input logic dm,
                         input logic lu, input logic rd, input logic hd);
        ihit = ih; dhit = dh; dmem_req = dm;
        load_use = lu; redirect = rd; halt_dec = hd;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (!halted && nRST) exp_cyc++;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        halted = 1'b0;
        exp_cyc = 0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1, 0, 1, 1, 1, 1);
        sb.push_back('{"rst_st", 32'({1'b0, RUN, 4'b0000})});
        sb.push_back('{"rst_cyc", 32'd0});
        sb.push_back('{"rst_stall", 32'd0});
        sb.push_back('{"rst_flush", 32'd0});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (cyc_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, cyc_cnt, e.v); end
        e = sb.pop_front(); checks++;
        if (stall_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, stall_cnt, e.v); end
        e = sb.pop_front(); checks++;
        if (flush_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, flush_cnt, e.v); end
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        sb.push_back('{"miss_ctl", 32'({1'b0, 4'b0001, 4'b1111})});
        sb.push_back('{"miss_st", 32'({1'b0, RUN, 4'b0000})});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
    endtask

    task automatic test_fill();
        logic [3:0] pat [4];
        pat = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            sb.push_back('{"fill_ctl", 32'({1'b1, 4'b0000, 4'b1111})});
            sb.push_back('{"fill_st", 32'({1'b0, RUN, pat[i]})});
            e = sb.pop_front(); checks++;
            if (32'(ctl) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, ctl, e.v); end
            step();
            e = sb.pop_front(); checks++;
            if (32'(st) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, st, e.v); end
        end
        sb.push_back('{"fill_stall", 32'd0});
        sb.push_back('{"fill_cyc", 32'(exp_cyc)});
        e = sb.pop_front(); checks++;
        if (stall_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, stall_cnt, e.v); end
        e = sb.pop_front(); checks++;
        if (cyc_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, cyc_cnt, e.v); end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 0);
            sb.push_back('{"frz_ctl", 32'd0});
            sb.push_back('{"frz_st", 32'({1'b0, RUN, 4'b1111})});
            e = sb.pop_front(); checks++;
            if (32'(ctl) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, ctl, e.v); end
            step();
            e = sb.pop_front(); checks++;
            if (32'(st) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, st, e.v); end
        end
        sb.push_back('{"frz_stall", 32'd3});
        e = sb.pop_front(); checks++;
        if (stall_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, stall_cnt, e.v); end
        drive(1, 1, 1, 0, 0, 0);
        sb.push_back('{"dhit_ctl", 32'({1'b1, 4'b0000, 4'b1111})});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
    endtask

    task automatic test_redirect();
        drive(0, 1, 0, 0, 1, 0);
        sb.push_back('{"red_ctl", 32'({1'b1, 4'b0011, 4'b1111})});
        sb.push_back('{"red_st", 32'({1'b0, RUN, 4'b1100})});
        sb.push_back('{"red_cnt", 32'd1});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (flush_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, flush_cnt, e.v); end
        drive(1, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 1, 0);
        sb.push_back('{"red_inv_ctl", 32'({1'b1, 4'b0000, 4'b1111})});
        sb.push_back('{"red_inv_st", 32'({1'b0, RUN, 4'b0011})});
        sb.push_back('{"red_inv_cnt", 32'd1});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (flush_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, flush_cnt, e.v); end
    endtask

    task automatic test_load_use();
        drive(1, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 1, 0, 0);
        sb.push_back('{"lu_ctl", 32'({1'b0, 4'b0010, 4'b1110})});
        sb.push_back('{"lu_st", 32'({1'b0, RUN, 4'b1101})});
        sb.push_back('{"lu_stall", 32'd4});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (stall_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, stall_cnt, e.v); end
        drive(0, 1, 0, 0, 0, 0);
        sb.push_back('{"imiss_ctl", 32'({1'b0, 4'b0001, 4'b1111})});
        sb.push_back('{"imiss_st", 32'({1'b0, RUN, 4'b1010})});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        drive(1, 1, 0, 1, 0, 0);
        sb.push_back('{"lu_inv_ctl", 32'({1'b1, 4'b0000, 4'b1111})});
        sb.push_back('{"lu_inv_st", 32'({1'b0, RUN, 4'b0101})});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
    endtask

    task automatic test_halt();
        logic [6:0] seq [3];
        seq = '{{1'b0, DRAIN, 4'b1100}, {1'b0, DRAIN, 4'b1000},
                {1'b1, HALTED, 4'b0000}};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, 0, 0, 0, 1);
        sb.push_back('{"hd_ctl", 32'({1'b0, 4'b0001, 4'b1111})});
        sb.push_back('{"hd_st", 32'({1'b0, DRAIN, 4'b1110})});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            sb.push_back('{"drn_ctl", 32'({1'b0, 4'b0001, 4'b1111})});
            sb.push_back('{"drn_st", 32'(seq[i])});
            e = sb.pop_front(); checks++;
            if (32'(ctl) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, ctl, e.v); end
            step();
            e = sb.pop_front(); checks++;
            if (32'(st) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, st, e.v); end
        end
        halted = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 1, 1, 1);
            sb.push_back('{"hlt_ctl", 32'd0});
            sb.push_back('{"hlt_st", 32'({1'b1, HALTED, 4'b0000})});
            sb.push_back('{"hlt_cyc", 32'(exp_cyc)});
            sb.push_back('{"hlt_stall", 32'd4});
            e = sb.pop_front(); checks++;
            if (32'(ctl) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, ctl, e.v); end
            step();
            e = sb.pop_front(); checks++;
            if (32'(st) !== e.v) begin errors++;
                $display("FAIL %s%0d got=%h exp=%h", e.nm, i, st, e.v); end
            e = sb.pop_front(); checks++;
            if (cyc_cnt !== e.v) begin errors++;
                $display("FAIL %s%0d got=%0d exp=%0d", e.nm, i, cyc_cnt, e.v); end
            e = sb.pop_front(); checks++;
            if (stall_cnt !== e.v) begin errors++;
                $display("FAIL %s%0d got=%0d exp=%0d", e.nm, i, stall_cnt, e.v); end
        end
    endtask

    task automatic test_drain_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, 0, 0, 0, 1);
        step();
        drive(1, 1, 0, 0, 1, 0);
        sb.push_back('{"dred_ctl", 32'({1'b1, 4'b0011, 4'b1111})});
        sb.push_back('{"dred_st", 32'({1'b0, RUN, 4'b1100})});
        sb.push_back('{"dred_cnt", 32'd1});
        e = sb.pop_front(); checks++;
        if (32'(ctl) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, ctl, e.v); end
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (flush_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, flush_cnt, e.v); end
    endtask

    task automatic test_reset_in_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, 0, 0, 0, 1);
        step();
        drive(1, 0, 1, 0, 0, 0);
        sb.push_back('{"dfrz_st", 32'({1'b0, DRAIN, 4'b1110})});
        step();
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        #2;
        nRST = 1'b0;
        sb.push_back('{"arst_st", 32'({1'b0, RUN, 4'b0000})});
        sb.push_back('{"arst_cyc", 32'd0});
        sb.push_back('{"arst_stall", 32'd0});
        sb.push_back('{"arst_flush", 32'd0});
        #1;
        e = sb.pop_front(); checks++;
        if (32'(st) !== e.v) begin errors++;
            $display("FAIL %s got=%h exp=%h", e.nm, st, e.v); end
        e = sb.pop_front(); checks++;
        if (cyc_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, cyc_cnt, e.v); end
        e = sb.pop_front(); checks++;
        if (stall_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, stall_cnt, e.v); end
        e = sb.pop_front(); checks++;
        if (flush_cnt !== e.v) begin errors++;
            $display("FAIL %s got=%0d exp=%0d", e.nm, flush_cnt, e.v); end
        #1;
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_freeze();
        test_redirect();
        test_load_use();
        test_halt();
        test_drain_redirect();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
